// File: rtl/sigma_arb_pkg.sv
// Shared types for the sigma RAM arbiter: master IDs, FSM states and the
// request bundle that is steered onto the slave port.
package sigma_arb_pkg;

  // Widest address/data the request bundle can carry.
  localparam int unsigned ARB_ADDR_W_MAX = 32;
  localparam int unsigned ARB_DATA_W_MAX = 32;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } mid_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic                          we;
    logic [ARB_ADDR_W_MAX-1:0]     addr;
    logic [ARB_DATA_W_MAX/8-1:0]   be;
    logic [ARB_DATA_W_MAX-1:0]     wdata;
  } req_t;

  function automatic req_t pack_req(
    input logic                        we,
    input logic [ARB_ADDR_W_MAX-1:0]   addr,
    input logic [ARB_DATA_W_MAX/8-1:0] be,
    input logic [ARB_DATA_W_MAX-1:0]   wdata
  );
    req_t r;
    r.we    = we;
    r.addr  = addr;
    r.be    = be;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/sigma_arb_idfifo.sv
// Small synchronous FIFO holding the master ID of every accepted read so
// that slave responses can be routed back in issue order.
module sigma_arb_idfifo
  import sigma_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (PTR_W+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  // A push into a full FIFO is legal only when a slot frees in the same cycle.
  assign do_push_s = push & (~full | do_pop_s);

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sigma_mem_arbiter.sv
// Two-master arbiter for the sigma on-chip RAM: m1 has fixed priority, m0 is
// protected by a starvation counter, read responses return in issue order.
module sigma_mem_arbiter
  import sigma_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RESP_DEPTH = 4,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_ack_o,
  output logic                m0_resp_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_ack_o,
  output logic                m1_resp_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W/8-1:0] s_be_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic                s_ack_i,
  input  logic                s_resp_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  output logic                err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  state_t            state_r;
  state_t            state_nxt_s;
  mid_t              owner_r;
  mid_t              owner_s;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic              err_r;
  logic [DATA_W-1:0] m0_rdata_r;
  logic [DATA_W-1:0] m1_rdata_r;
  req_t              m0_bundle_s;
  req_t              m1_bundle_s;
  req_t              sel_s;
  logic              s_req_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic [0:0]        fifo_head_s;

  assign m0_bundle_s = pack_req(m0_we_i, ARB_ADDR_W_MAX'(m0_addr_i),
                                (ARB_DATA_W_MAX/8)'(m0_be_i), ARB_DATA_W_MAX'(m0_wdata_i));
  assign m1_bundle_s = pack_req(m1_we_i, ARB_ADDR_W_MAX'(m1_addr_i),
                                (ARB_DATA_W_MAX/8)'(m1_be_i), ARB_DATA_W_MAX'(m1_wdata_i));

  // Owner selection: frozen while LOCKED, otherwise starvation guard then m1 priority.
  always_comb begin
    owner_s = M0;
    if (state_r == LOCKED) begin
      owner_s = owner_r;
    end else if (m0_req_i && (wait_cnt_r == CNT_W'(MAX_WAIT))) begin
      owner_s = M0;
    end else if (m1_req_i) begin
      owner_s = M1;
    end else begin
      owner_s = M0;
    end
  end

  assign sel_s      = (owner_s == M1) ? m1_bundle_s : m0_bundle_s;
  assign fifo_pop_s = s_resp_i & ~fifo_empty_s;

  // Slave request: reads are held off while every response slot is in use.
  always_comb begin
    s_req_s = 1'b0;
    case (state_r)
      LOCKED:  s_req_s = 1'b1;
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          s_req_s = sel_s.we | ~fifo_full_s | fifo_pop_s;
        end else begin
          s_req_s = 1'b0;
        end
      end
      default: s_req_s = 1'b0;
    endcase
  end

  // Next-state: an un-accepted request locks the slave port to its owner.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (s_req_s && !s_ack_i) state_nxt_s = LOCKED;
        else                     state_nxt_s = IDLE;
      end
      LOCKED: begin
        if (s_ack_i) state_nxt_s = IDLE;
        else         state_nxt_s = LOCKED;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  assign s_req_o     = s_req_s;
  assign s_we_o      = sel_s.we;
  assign s_addr_o    = sel_s.addr[ADDR_W-1:0];
  assign s_be_o      = sel_s.be[DATA_W/8-1:0];
  assign s_wdata_o   = sel_s.wdata[DATA_W-1:0];
  assign m0_ack_o    = s_ack_i & s_req_s & (owner_s == M0);
  assign m1_ack_o    = s_ack_i & s_req_s & (owner_s == M1);
  assign fifo_push_s = s_req_s & s_ack_i & ~sel_s.we;
  assign m0_resp_o   = fifo_pop_s & (mid_t'(fifo_head_s) == M0);
  assign m1_resp_o   = fifo_pop_s & (mid_t'(fifo_head_s) == M1);
  assign m0_rdata_o  = m0_resp_o ? s_rdata_i : m0_rdata_r;
  assign m1_rdata_o  = m1_resp_o ? s_rdata_i : m1_rdata_r;
  assign err_o       = err_r;

  // FSM, latched owner, starvation counter, sticky error and held read data.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r    <= IDLE;
      owner_r    <= M0;
      wait_cnt_r <= '0;
      err_r      <= 1'b0;
      m0_rdata_r <= '0;
      m1_rdata_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == IDLE && state_nxt_s == LOCKED) begin
        owner_r <= owner_s;
      end
      if (!m0_req_i || m0_ack_o) begin
        wait_cnt_r <= '0;
      end else if (wait_cnt_r != CNT_W'(MAX_WAIT)) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end
      if (s_resp_i && fifo_empty_s) begin
        err_r <= 1'b1;
      end
      if (m0_resp_o) m0_rdata_r <= s_rdata_i;
      if (m1_resp_o) m1_rdata_r <= s_rdata_i;
    end
  end

  sigma_arb_idfifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH ($bits(mid_t))
  ) u_idfifo (
    .clk   (clk_i),
    .rst_n (arst_n_i),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (owner_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (fifo_head_s)
  );

endmodule

// File: tb/tb_sigma_mem_arbiter.sv
// Directed self-checking bench for sigma_mem_arbiter; the bench plays the
// slave by driving s_ack_i / s_resp_i cycle by cycle.
module tb_sigma_mem_arbiter;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ack, m0_resp, m1_ack, m1_resp;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_ack, s_resp;
  logic [31:0] s_rdata;
  logic        err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_m0;
  logic [31:0] last_m1;

  always #5 clk = ~clk;

  sigma_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RESP_DEPTH(4), .MAX_WAIT(8)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_be_i(m0_be),
    .m0_wdata_i(m0_wdata), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_o(m1_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_be_o(s_be), .s_wdata_o(s_wdata),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata), .err_o(err)
  );

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_be = 4'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_be = 4'h0; m1_wdata = 32'h0;
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if ({s_req, m0_ack, m1_ack, m0_resp, m1_resp, err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 000000", {s_req, m0_ack, m1_ack, m0_resp, m1_resp, err});
    end
    checks++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h/%h expected 0/0", m0_rdata, m1_rdata);
    end
    @(negedge clk);
    arst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_be = 4'hF; s_ack = 1'b1;
    #1;
    checks++;
    if ({m0_ack, m1_ack, s_req, s_we} !== 4'b1010) begin
      failures++;
      $display("FAIL single_ack: got %b expected 1010", {m0_ack, m1_ack, s_req, s_we});
    end
    checks++;
    if (s_addr !== 32'h100) begin
      failures++;
      $display("FAIL single_addr: got %h expected 00000100", s_addr);
    end
    step();
    idle_inputs();
    s_resp = 1'b1; s_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({m0_resp, m1_resp} !== 2'b10 || m0_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_resp: got %b/%h expected 10/deadbeef", {m0_resp, m1_resp}, m0_rdata);
    end
    checks++;
    if (m1_rdata !== 32'h0) begin
      failures++;
      $display("FAIL single_m1_idle: got %h expected 00000000", m1_rdata);
    end
    step();
    s_resp = 1'b0; s_rdata = 32'h0;
    #1;
    checks++;
    if (m0_resp !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_hold: got %b/%h expected 0/deadbeef", m0_resp, m0_rdata);
    end
    last_m0 = 32'hDEADBEEF;
    step();
  endtask

  task automatic test_starvation();
    logic exp_m0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'hA0; m0_be = 4'hC; m0_wdata = 32'h0000_00A0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hB0; m1_be = 4'h3; m1_wdata = 32'h0000_00B0;
    s_ack = 1'b1;
    for (int i = 0; i < 18; i++) begin
      exp_m0 = (i % 9 == 8);
      #1;
      checks++;
      if ({m0_ack, m1_ack} !== {exp_m0, ~exp_m0}) begin
        failures++;
        $display("FAIL starve_ack cyc%0d: got %b expected %b", i, {m0_ack, m1_ack}, {exp_m0, ~exp_m0});
      end
      checks++;
      if (s_addr !== (exp_m0 ? 32'hA0 : 32'hB0) || s_be !== (exp_m0 ? 4'hC : 4'h3)) begin
        failures++;
        $display("FAIL starve_mux cyc%0d: got %h/%h expected %h/%h", i, s_addr, s_be,
                 exp_m0 ? 32'hA0 : 32'hB0, exp_m0 ? 4'hC : 4'h3);
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_locked();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200; m1_be = 4'hF;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h300; m0_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      s_ack = (i == 3);
      #1;
      checks++;
      if (s_addr !== 32'h200 || s_req !== 1'b1) begin
        failures++;
        $display("FAIL locked_addr cyc%0d: got %h/%b expected 00000200/1", i, s_addr, s_req);
      end
      checks++;
      if ({m0_ack, m1_ack} !== {1'b0, (i == 3)}) begin
        failures++;
        $display("FAIL locked_ack cyc%0d: got %b expected %b", i, {m0_ack, m1_ack}, {1'b0, (i == 3)});
      end
      step();
    end
    idle_inputs();
    s_resp = 1'b1; s_rdata = 32'hCAFE0200;
    #1;
    checks++;
    if ({m0_resp, m1_resp} !== 2'b01 || m1_rdata !== 32'hCAFE0200) begin
      failures++;
      $display("FAIL locked_resp: got %b/%h expected 01/cafe0200", {m0_resp, m1_resp}, m1_rdata);
    end
    last_m1 = 32'hCAFE0200;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_fifo_order();
    int          ids [4]  = '{1, 0, 1, 0};
    int          rids [4] = '{0, 1, 0, 1};
    logic [31:0] rdat [4] = '{32'h22, 32'h33, 32'h44, 32'h55};
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      s_ack = 1'b1;
      if (ids[i] == 1) begin
        m1_req = 1'b1; m1_addr = 32'h10 * (i + 1);
      end else begin
        m0_req = 1'b1; m0_addr = 32'h10 * (i + 1);
      end
      #1;
      checks++;
      if ({s_req, m1_ack, m0_ack} !== {1'b1, ids[i] == 1, ids[i] == 0}) begin
        failures++;
        $display("FAIL fifo_fill%0d: got %b expected %b", i, {s_req, m1_ack, m0_ack},
                 {1'b1, ids[i] == 1, ids[i] == 0});
      end
      step();
    end
    idle_inputs();
    m1_req = 1'b1; m1_addr = 32'h50; s_ack = 1'b1;
    #1;
    checks++;
    if ({s_req, m1_ack} !== 2'b00) begin
      failures++;
      $display("FAIL fifo_gate: got %b expected 00", {s_req, m1_ack});
    end
    step();
    s_resp = 1'b1; s_rdata = 32'h11;
    #1;
    checks++;
    if ({s_req, m1_ack, m1_resp, m0_resp} !== 4'b1110 || m1_rdata !== 32'h11) begin
      failures++;
      $display("FAIL fifo_pushpop: got %b/%h expected 1110/00000011", {s_req, m1_ack, m1_resp, m0_resp}, m1_rdata);
    end
    last_m1 = 32'h11;
    step();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      s_resp = 1'b1; s_rdata = rdat[i];
      #1;
      checks++;
      if ({m0_resp, m1_resp} !== {rids[i] == 0, rids[i] == 1}) begin
        failures++;
        $display("FAIL fifo_route%0d: got %b expected %b", i, {m0_resp, m1_resp}, {rids[i] == 0, rids[i] == 1});
      end
      if (rids[i] == 0) last_m0 = rdat[i];
      else              last_m1 = rdat[i];
      checks++;
      if (m0_rdata !== last_m0 || m1_rdata !== last_m1) begin
        failures++;
        $display("FAIL fifo_rdata%0d: got %h/%h expected %h/%h", i, m0_rdata, m1_rdata, last_m0, last_m1);
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_spurious();
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL spur_pre_err: got %b expected 0", err);
    end
    s_resp = 1'b1; s_rdata = 32'h99;
    #1;
    checks++;
    if ({m0_resp, m1_resp} !== 2'b00) begin
      failures++;
      $display("FAIL spur_resp: got %b expected 00", {m0_resp, m1_resp});
    end
    step();
    idle_inputs();
    step();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL spur_sticky: got %b expected 1", err);
    end
    arst_n = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0 || m0_rdata !== 32'h0) begin
      failures++;
      $display("FAIL spur_async_clr: got %b/%h expected 0/00000000", err, m0_rdata);
    end
    @(negedge clk);
    arst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_outstanding();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h400; m0_be = 4'hF; s_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (m0_ack !== 1'b1) begin
        failures++;
        $display("FAIL rst_out_ack%0d: got %b expected 1", i, m0_ack);
      end
      step();
    end
    idle_inputs();
    #2;
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    step();
    s_resp = 1'b1; s_rdata = 32'h77;
    #1;
    checks++;
    if ({m0_resp, m1_resp} !== 2'b00) begin
      failures++;
      $display("FAIL rst_out_resp: got %b expected 00", {m0_resp, m1_resp});
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL rst_out_err: got %b expected 1", err);
    end
    step();
  endtask

  initial begin
    last_m0 = 32'h0;
    last_m1 = 32'h0;
    test_reset();
    test_single_read();
    test_starvation();
    test_locked();
    test_fifo_order();
    test_spurious();
    test_reset_outstanding();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/sigma_mem_arbiter.md
Name: sigma_mem_arbiter

Overview:
- Shares one sigma on-chip RAM slave port between two bus masters:
  - m0: riscv_5stage CPU data port.
  - m1: sobel accelerator / DMA engine.
- Uses the activecore req/ack + resp/rdata handshake on every port.
- Fixed priority to m1, with a starvation guard for m0.
- Read responses are routed back in order through an ID FIFO.
- Sits between the CPU/accelerator and the RAM inside sigma.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- RESP_DEPTH, 4, maximum outstanding reads; power of 2, at least 2.
- MAX_WAIT, 8, number of consecutive cycles m0 may lose arbitration before it is force-granted once.

Ports:
- clk_i  in  1  system clock.
- arst_n_i  in  1  asynchronous reset, active-low.
- m0_req_i / m1_req_i  in  1  master request.
- m0_we_i / m1_we_i  in  1  write enable; 1 = write, 0 = read.
- m0_addr_i / m1_addr_i  in  ADDR_W  address.
- m0_be_i / m1_be_i  in  DATA_W/8  byte enables.
- m0_wdata_i / m1_wdata_i  in  DATA_W  write data.
- m0_ack_o / m1_ack_o  out  1  request accepted this cycle.
- m0_resp_o / m1_resp_o  out  1  read data valid.
- m0_rdata_o / m1_rdata_o  out  DATA_W  read data.
- s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o  out  1/1/ADDR_W/DATA_W/8/DATA_W  slave request.
- s_ack_i  in  1  slave accepted request.
- s_resp_i  in  1  slave read data valid.
- s_rdata_i  in  DATA_W  slave read data.
- err_o  out  1  sticky error: s_resp_i arrived with no pending read.

Behaviour:
- Reset (arst_n_i=0, asynchronous):
  - FSM goes to IDLE.
  - ID FIFO is emptied; any pending responses are dropped.
  - wait_cnt=0, err_o=0.
  - All *_ack_o, *_resp_o and s_req_o are 0; rdata outputs are 0.
- FSM state IDLE:
  - Owner is chosen combinationally:
    - m0 if wait_cnt==MAX_WAIT and m0_req_i;
    - otherwise m1 if m1_req_i;
    - otherwise m0 if m0_req_i.
  - The owner's we/addr/be/wdata drive s_* in the same cycle (zero added latency); s_req_o=1.
  - If s_ack_i=1 in that cycle, the transaction completes and the FSM stays in IDLE.
  - If s_ack_i=0, the FSM goes to LOCKED with the owner latched.
- FSM state LOCKED:
  - s_* continue to be driven from the latched owner's inputs.
  - Arbitration is frozen until s_ack_i=1, then the FSM returns to IDLE.
  - A master deasserting req while LOCKED is a protocol violation; the arbiter still holds the owner.
- Acknowledge: owner's *_ack_o = s_ack_i & s_req_o; the non-owner's ack is 0.
- Read gating:
  - When the FIFO is full and the owner's request is a read, s_req_o=0.
  - The FIFO push and the pop of a responding slot count as simultaneous, so a read is not gated when a pop occurs in the same cycle.
  - Writes are never gated.
  - Under gating the FSM stays in IDLE, and the owner is re-evaluated every cycle.
- ID FIFO:
  - Push owner ID on s_req_o & s_ack_i & !s_we_o.
  - Pop on s_resp_i.
  - Simultaneous push and pop is allowed; occupancy is unchanged.
  - Read and write pointers wrap modulo RESP_DEPTH.
- Response routing:
  - On s_resp_i, the FIFO head ID selects the master.
  - That master's *_resp_o=1 with rdata=s_rdata_i, in the same cycle (combinational).
  - The other master's rdata is held at its last value.
- Spurious response: s_resp_i with an empty FIFO sets err_o; neither master sees resp, and the FIFO is unchanged.
- Starvation counter (wait_cnt):
  - Increments, saturating at MAX_WAIT, on every cycle m0_req_i=1 and m0 is not acked.
  - Clears on an m0 ack, or whenever m0_req_i=0.
- Writes generate no response.
- Byte enables pass through unmodified.

Decomposition:
- Package sigma_arb_pkg holds:
  - the master ID typedef (1 bit, M0=0, M1=1);
  - the FSM state enum {IDLE, LOCKED};
  - a request struct {we, addr, be, wdata}.
- Sub-module sigma_arb_idfifo: parameterised depth/width synchronous FIFO.
  - Ports: push/pop/full/empty/head.
  - Asynchronous active-low clear.

Test Plan:
- Only m0 issues a read to addr 0x100; slave acks the same cycle; resp one cycle later with 0xDEADBEEF -> m0_ack_o in cycle 0, m0_resp_o=1 with m0_rdata_o=0xDEADBEEF, m1 outputs idle.
- Both masters request continuously, slave always acks -> m1 wins 8 consecutive cycles, m0 granted on the 9th, wait_cnt returns to 0, pattern repeats.
- m1 read to 0x200 with s_ack_i held 0 for 3 cycles while m0 also requests -> s_addr_o stays 0x200 for all 4 cycles, m0_ack_o=0 throughout, m1_ack_o=1 in cycle 4.
- Interleaved accepted reads m1, m0, m1, m0 with no responses -> the fifth read is gated (s_req_o=0); the first s_resp_i routes to m1, the next three to m0, m1, m0 in order.
- Assert s_resp_i with no reads outstanding -> err_o=1 sticky, no *_resp_o; apply arst_n_i=0 -> err_o=0 immediately.
- Assert reset with 2 reads outstanding, then release -> FIFO is empty, and a later s_resp_i sets err_o.
